// File: rtl/servo_pwm_pkg.sv
// -----------------------------------------------------------------------------
// servo_pwm_pkg
// Shared definitions for the multi-channel servo PWM peripheral.
//   - Register word indices as decoded from wb_adr[6:2]
//   - CTRL and STATUS field positions
//   - byte_mask(): expands a Wishbone byte select into a 32-bit bit mask
// -----------------------------------------------------------------------------
package servo_pwm_pkg;

    // Word indices (byte offset >> 2) of the register map.
    localparam logic [4:0] REG_CTRL       = 5'h00;  // byte offset 0x00
    localparam logic [4:0] REG_PERIOD     = 5'h01;  // byte offset 0x04
    localparam logic [4:0] REG_STATUS     = 5'h02;  // byte offset 0x08
    localparam logic [4:0] REG_SLEW       = 5'h03;  // byte offset 0x0C
    localparam logic [4:0] REG_WIDTH_BASE = 5'h10;  // byte offset 0x40

    // CTRL field positions.
    localparam int CTRL_EN_BIT = 0;
    localparam int CTRL_CH_LSB = 8;

    // STATUS field positions.
    localparam int STATUS_PEND_BIT = 0;
    localparam int STATUS_FCNT_LSB = 16;

    // Each set bit of sel enables the matching byte lane of the write data.
    function automatic logic [31:0] byte_mask(input logic [3:0] sel);
        logic [31:0] mask;
        mask = '0;
        for (int b = 0; b < 4; b++) begin
            mask[8*b +: 8] = {8{sel[b]}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/servo_pwm_chan.sv
// -----------------------------------------------------------------------------
// servo_pwm_chan
// One PWM channel: staged width register (written over Wishbone), active
// width used for comparison, optional slew limiter, and the registered
// output compare flop.
//
// Optional feature macro: SERVO_SLEW_EN (adds the slew input and limiter).
//
// Ports
//   wb_clk        clock
//   wb_rst_n      asynchronous active-low reset
//   counter       shared frame counter value
//   wrap          frame boundary: counter is on its last count
//   load_now      copy staged width to active immediately (counter stopped)
//   enable        channel output enable (global & channel & period != 0)
//   slew          max width change per frame, 0 = unlimited (SERVO_SLEW_EN)
//   wr_en         write strobe for the staged width
//   wr_data       write data, already truncated to CNT_W
//   wr_mask       per-bit write enable derived from the byte selects
//   staged_width  staged width for read-back
//   pending       staged width differs from active width
//   pwm           registered PWM output
// -----------------------------------------------------------------------------
module servo_pwm_chan
    import servo_pwm_pkg::*;
#(
    parameter int CNT_W = 24
) (
    input  logic             wb_clk,
    input  logic             wb_rst_n,
    input  logic [CNT_W-1:0] counter,
    input  logic             wrap,
    input  logic             load_now,
    input  logic             enable,
`ifdef SERVO_SLEW_EN
    input  logic [CNT_W-1:0] slew,
`endif
    input  logic             wr_en,
    input  logic [CNT_W-1:0] wr_data,
    input  logic [CNT_W-1:0] wr_mask,
    output logic [CNT_W-1:0] staged_width,
    output logic             pending,
    output logic             pwm
);

    logic [CNT_W-1:0] active_width;
    logic [CNT_W-1:0] next_width;

`ifdef SERVO_SLEW_EN
    logic [CNT_W-1:0] gap;

    // Step the active width toward the staged one by at most 'slew' per
    // frame; a zero slew or a gap within one step lands exactly on target.
    always_comb begin
        next_width = staged_width;
        gap        = (staged_width > active_width) ? (staged_width - active_width)
                                                   : (active_width - staged_width);
        if ((slew != '0) && (gap > slew)) begin
            if (staged_width > active_width) begin
                next_width = active_width + slew;
            end else begin
                next_width = active_width - slew;
            end
        end
    end
`else
    assign next_width = staged_width;
`endif

    // Staged register takes bus writes at any time; the active copy only
    // changes at a frame boundary (or immediately while the counter is
    // stopped), so a pulse in progress is never cut or stretched.
    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            staged_width <= '0;
            active_width <= '0;
            pwm          <= 1'b0;
        end else begin
            if (wr_en) begin
                staged_width <= (staged_width & ~wr_mask) | (wr_data & wr_mask);
            end
            if (load_now) begin
                active_width <= staged_width;
            end else if (wrap) begin
                active_width <= next_width;
            end
            pwm <= enable && (counter < active_width);
        end
    end

    assign pending = (staged_width != active_width);

endmodule

// File: rtl/servo_pwm_multi.sv
// -----------------------------------------------------------------------------
// servo_pwm_multi
// Multi-channel servo PWM generator with a Wishbone slave port. One shared
// frame counter drives NUM_CH compare channels. Period and widths are
// double-buffered and move to their active copies at frame boundaries.
//
// Optional feature macro: SERVO_SLEW_EN (SLEW register and per-frame width
// slew limiting). Without it SLEW reads 0 and widths update in one step.
//
// Ports
//   wb_clk      clock for all logic
//   wb_rst_n    asynchronous active-low reset
//   wb_cyc      Wishbone cycle valid
//   wb_stb      Wishbone strobe
//   wb_we       Wishbone write enable
//   wb_sel      Wishbone byte selects
//   wb_adr      byte address, bits [6:2] decoded
//   wb_dat_i    write data
//   wb_ack      acknowledge, one cycle after the request
//   wb_dat_o    registered read data, valid with wb_ack
//   pwm_out     registered PWM outputs
//   frame_tick  one-cycle pulse as the counter returns to 0
// -----------------------------------------------------------------------------
module servo_pwm_multi
    import servo_pwm_pkg::*;
#(
    parameter int NUM_CH         = 4,
    parameter int CNT_W          = 24,
    parameter int DEFAULT_PERIOD = 2000000
) (
    input  logic              wb_clk,
    input  logic              wb_rst_n,
    input  logic              wb_cyc,
    input  logic              wb_stb,
    input  logic              wb_we,
    input  logic [3:0]        wb_sel,
    input  logic [31:0]       wb_adr,
    input  logic [31:0]       wb_dat_i,
    output logic              wb_ack,
    output logic [31:0]       wb_dat_o,
    output logic [NUM_CH-1:0] pwm_out,
    output logic              frame_tick
);

    logic [31:0]      wb_mask;
    logic             wb_req;
    logic             wr_req;
    logic [4:0]       reg_idx;
    logic [CNT_W-1:0] wr_data;
    logic [CNT_W-1:0] wr_mask;

    logic              ctrl_en;
    logic [NUM_CH-1:0] ch_en;
    logic [CNT_W-1:0]  staged_period;
    logic [CNT_W-1:0]  active_period;
    logic [CNT_W-1:0]  counter;
    logic [15:0]       frame_count;
    logic              period_nonzero;
    logic              wrap;
    logic              load_now;
    logic              update_pending;
    logic [31:0]       rd_word;

    logic [CNT_W-1:0]  staged_w [NUM_CH];
    logic [NUM_CH-1:0] ch_pend;

`ifdef SERVO_SLEW_EN
    logic [CNT_W-1:0]  slew_reg;
`endif

    // Address bits outside [6:2] and data/mask bits above the register
    // width are intentionally ignored.
    logic unused_bits;
    assign unused_bits = ^{wb_adr[31:7], wb_adr[1:0], wb_dat_i, wb_mask};

    assign wb_mask = byte_mask(wb_sel);
    assign wb_req  = wb_cyc & wb_stb & ~wb_ack;
    assign wr_req  = wb_req & wb_we;
    assign reg_idx = wb_adr[6:2];
    assign wr_data = wb_dat_i[CNT_W-1:0];
    assign wr_mask = wb_mask[CNT_W-1:0];

    // The counter stops whenever the block is disabled or the period is 0;
    // in that state staged values are copied straight into the active set.
    assign period_nonzero = (active_period != '0);
    assign load_now       = !ctrl_en || !period_nonzero;
    assign wrap           = ctrl_en && period_nonzero &&
                            (counter == active_period - CNT_W'(1));

    // Wishbone handshake: ack the cycle after the request; a held strobe
    // therefore sees ack on alternate cycles. Read data is captured on the
    // request cycle so it lines up with ack.
    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            wb_ack   <= 1'b0;
            wb_dat_o <= '0;
        end else begin
            wb_ack   <= wb_req;
            wb_dat_o <= (wb_req && !wb_we) ? rd_word : '0;
        end
    end

    // CTRL and staged PERIOD registers, written byte-lane by byte-lane.
    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            ctrl_en       <= 1'b0;
            ch_en         <= '0;
            staged_period <= CNT_W'(DEFAULT_PERIOD);
        end else if (wr_req) begin
            if (reg_idx == REG_CTRL) begin
                if (wb_mask[CTRL_EN_BIT]) begin
                    ctrl_en <= wb_dat_i[CTRL_EN_BIT];
                end
                for (int i = 0; i < NUM_CH; i++) begin
                    if (wb_mask[CTRL_CH_LSB+i]) begin
                        ch_en[i] <= wb_dat_i[CTRL_CH_LSB+i];
                    end
                end
            end
            if (reg_idx == REG_PERIOD) begin
                staged_period <= (staged_period & ~wr_mask) | (wr_data & wr_mask);
            end
        end
    end

`ifdef SERVO_SLEW_EN
    // Slew limit applied to every channel at each frame boundary.
    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            slew_reg <= '0;
        end else if (wr_req && (reg_idx == REG_SLEW)) begin
            slew_reg <= (slew_reg & ~wr_mask) | (wr_data & wr_mask);
        end
    end
`endif

    // Frame counter: counts 0..P-1, pulses frame_tick as it returns to 0
    // and swaps in the staged period at that point. A write that lands on
    // the wrap cycle updates the staged copy after it has been sampled, so
    // it waits for the following wrap.
    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            counter       <= '0;
            active_period <= CNT_W'(DEFAULT_PERIOD);
            frame_tick    <= 1'b0;
            frame_count   <= '0;
        end else begin
            frame_tick <= wrap;
            if (load_now) begin
                counter       <= '0;
                active_period <= staged_period;
            end else if (wrap) begin
                counter       <= '0;
                active_period <= staged_period;
                frame_count   <= frame_count + 16'd1;
            end else begin
                counter <= counter + CNT_W'(1);
            end
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
        servo_pwm_chan #(
            .CNT_W (CNT_W)
        ) u_chan (
            .wb_clk       (wb_clk),
            .wb_rst_n     (wb_rst_n),
            .counter      (counter),
            .wrap         (wrap),
            .load_now     (load_now),
            .enable       (ctrl_en & ch_en[i] & period_nonzero),
`ifdef SERVO_SLEW_EN
            .slew         (slew_reg),
`endif
            .wr_en        (wr_req && (reg_idx == REG_WIDTH_BASE + 5'(i))),
            .wr_data      (wr_data),
            .wr_mask      (wr_mask),
            .staged_width (staged_w[i]),
            .pending      (ch_pend[i]),
            .pwm          (pwm_out[i])
        );
    end

    assign update_pending = (staged_period != active_period) | (|ch_pend);

    // Read mux: unmapped words and bits above each field read as 0.
    always_comb begin
        rd_word = '0;
        case (reg_idx)
            REG_CTRL: begin
                rd_word[CTRL_EN_BIT]           = ctrl_en;
                rd_word[CTRL_CH_LSB +: NUM_CH] = ch_en;
            end
            REG_PERIOD: begin
                rd_word[CNT_W-1:0] = staged_period;
            end
            REG_STATUS: begin
                rd_word[STATUS_PEND_BIT]         = update_pending;
                rd_word[STATUS_FCNT_LSB +: 16]   = frame_count;
            end
`ifdef SERVO_SLEW_EN
            REG_SLEW: begin
                rd_word[CNT_W-1:0] = slew_reg;
            end
`endif
            default: begin
                for (int i = 0; i < NUM_CH; i++) begin
                    if (reg_idx == REG_WIDTH_BASE + 5'(i)) begin
                        rd_word[CNT_W-1:0] = staged_w[i];
                    end
                end
            end
        endcase
    end

endmodule
